// File: rtl/pcileech_board_ctl.sv
// Board-support controller: debounced buttons, sequenced downstream reset and
// per-LED display modes (off/on/blink/activity) with optional output inversion.
module pcileech_board_ctl #(
  parameter int NUM_BTN         = 2,
  parameter int NUM_LED         = 2,
  parameter int RST_BTN_IDX     = 1,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int RST_HOLD_CYCLES = 1024,
  parameter int BLINK_DIV_LOG2  = 24,
  parameter int STRETCH_CYCLES  = 2**20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BTN-1:0]   btn_n,
  output logic [NUM_BTN-1:0]   btn_level,
  output logic [NUM_BTN-1:0]   btn_press,
  output logic                 rst_sys,
  input  logic [2*NUM_LED-1:0] led_mode,
  input  logic [NUM_LED-1:0]   led_act,
  input  logic [NUM_LED-1:0]   led_invert,
  output logic [NUM_LED-1:0]   led_out
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int HC_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int SC_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(RST_HOLD_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(STRETCH_CYCLES);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_BTN} state_t;

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] stable_q, stable_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_d [NUM_BTN];

  state_t             state_q, state_d;
  logic [HC_W-1:0]    hcnt_q, hcnt_d;
  logic               rst_sys_q, rst_sys_d;

  logic [BLINK_DIV_LOG2-1:0] blink_cnt_q, blink_cnt_d;
  logic [SC_W-1:0]    scnt_q [NUM_LED];
  logic [SC_W-1:0]    scnt_d [NUM_LED];
  logic [NUM_LED-1:0] led_out_q, led_out_d;

  // Debounce: a level must differ from the accepted state for DEBOUNCE_CYCLES
  // consecutive cycles; any return to the accepted level restarts the count.
  always_comb begin
    for (int b = 0; b < NUM_BTN; b++) begin
      stable_d[b] = stable_q[b];
      db_cnt_d[b] = '0;
      if (sync2_q[b] != stable_q[b]) begin
        if (db_cnt_q[b] == DB_MAX) begin
          stable_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
    press_d = stable_d & ~stable_q;
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      S_HOLD: begin
        if (stable_q[RST_BTN_IDX]) begin
          state_d = S_BTN;
          hcnt_d  = '0;
        end else if (hcnt_q == HC_MAX) begin
          state_d = S_RUN;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (stable_q[RST_BTN_IDX]) state_d = S_BTN;
      end
      S_BTN: begin
        if (!stable_q[RST_BTN_IDX]) begin
          state_d = S_HOLD;
          hcnt_d  = '0;
        end
      end
      default: begin
        state_d = S_HOLD;
        hcnt_d  = '0;
      end
    endcase
    rst_sys_d = (state_d != S_RUN);
  end

  // Activity uses the next stretch value so a strobe shows on led_out one cycle later.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    for (int l = 0; l < NUM_LED; l++) begin
      if (led_act[l]) begin
        scnt_d[l] = SC_LOAD;
      end else if (scnt_q[l] != '0) begin
        scnt_d[l] = scnt_q[l] - 1'b1;
      end else begin
        scnt_d[l] = scnt_q[l];
      end
      unique case (led_mode[2*l +: 2])
        2'b00:   led_out_d[l] = 1'b0;
        2'b01:   led_out_d[l] = 1'b1;
        2'b10:   led_out_d[l] = blink_cnt_q[BLINK_DIV_LOG2-1];
        default: led_out_d[l] = (scnt_d[l] != '0);
      endcase
      led_out_d[l] = led_out_d[l] ^ led_invert[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      press_q     <= '0;
      state_q     <= S_HOLD;
      hcnt_q      <= '0;
      rst_sys_q   <= 1'b1;
      blink_cnt_q <= '0;
      led_out_q   <= '0;
      for (int b = 0; b < NUM_BTN; b++) db_cnt_q[b] <= '0;
      for (int l = 0; l < NUM_LED; l++) scnt_q[l] <= '0;
    end else begin
      sync1_q     <= ~btn_n;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      press_q     <= press_d;
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      rst_sys_q   <= rst_sys_d;
      blink_cnt_q <= blink_cnt_d;
      led_out_q   <= led_out_d;
      for (int b = 0; b < NUM_BTN; b++) db_cnt_q[b] <= db_cnt_d[b];
      for (int l = 0; l < NUM_LED; l++) scnt_q[l] <= scnt_d[l];
    end
  end

  assign btn_level = stable_q;
  assign btn_press = press_q;
  assign rst_sys   = rst_sys_q;
  assign led_out   = led_out_q;

endmodule

// File: tb/tb_pcileech_board_ctl.sv
// Scoreboard bench for pcileech_board_ctl with short debounce/hold/blink/stretch settings.
module tb_pcileech_board_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn_n = 2'b11;
  logic [1:0] btn_level, btn_press;
  logic       rst_sys;
  logic [3:0] led_mode = 4'b0000;
  logic [1:0] led_act = 2'b00;
  logic [1:0] led_invert = 2'b00;
  logic [1:0] led_out;

  typedef struct packed {
    logic       rsys;
    logic [1:0] lvl;
    logic [1:0] press;
    logic [1:0] led;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass = 0;

  pcileech_board_ctl #(
    .NUM_BTN(2), .NUM_LED(2), .RST_BTN_IDX(1), .DEBOUNCE_CYCLES(4),
    .RST_HOLD_CYCLES(8), .BLINK_DIV_LOG2(3), .STRETCH_CYCLES(5)
  ) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .btn_level(btn_level),
    .btn_press(btn_press), .rst_sys(rst_sys), .led_mode(led_mode),
    .led_act(led_act), .led_invert(led_invert), .led_out(led_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 1; i <= 3; i++) begin
      sbq.push_back('{rsys: 1'b1, lvl: 2'b00, press: 2'b00, led: 2'b00});
      tick();
      e = sbq.pop_front();
      n_checks++;
      if (rst_sys !== e.rsys) $display("FAIL rst_in_reset cyc=%0d got=%b exp=%b", i, rst_sys, e.rsys);
      else n_pass++;
      n_checks++;
      if ({btn_level, btn_press, led_out} !== {e.lvl, e.press, e.led})
        $display("FAIL outs_in_reset cyc=%0d got=%b exp=%b", i, {btn_level, btn_press, led_out}, {e.lvl, e.press, e.led});
      else n_pass++;
    end
    rst = 1'b0;
    // rst_sys stays high for the cycle rst drops plus 7 more, then falls for good
    for (int i = 1; i <= 14; i++) begin
      sbq.push_back('{rsys: (i <= 7), lvl: 2'b00, press: 2'b00, led: 2'b00});
      tick();
      e = sbq.pop_front();
      n_checks++;
      if (rst_sys !== e.rsys) $display("FAIL rst_hold cyc=%0d got=%b exp=%b", i, rst_sys, e.rsys);
      else n_pass++;
      n_checks++;
      if (led_out !== e.led) $display("FAIL led_idle cyc=%0d got=%b exp=%b", i, led_out, e.led);
      else n_pass++;
    end
  endtask

  task automatic test_debounce();
    for (int i = 1; i <= 12; i++) begin
      btn_n[0] = (i <= 3) ? 1'b0 : 1'b1;
      sbq.push_back('{rsys: 1'b0, lvl: 2'b00, press: 2'b00, led: 2'b00});
      tick();
      e = sbq.pop_front();
      n_checks++;
      if ({btn_level, btn_press} !== {e.lvl, e.press})
        $display("FAIL glitch cyc=%0d got=%b exp=%b", i, {btn_level, btn_press}, {e.lvl, e.press});
      else n_pass++;
    end
    for (int i = 1; i <= 10; i++) begin
      btn_n[0] = 1'b0;
      sbq.push_back('{rsys: 1'b0, lvl: {1'b0, i >= 6}, press: {1'b0, i == 6}, led: 2'b00});
      tick();
      e = sbq.pop_front();
      n_checks++;
      if ({btn_level, btn_press} !== {e.lvl, e.press})
        $display("FAIL press cyc=%0d got=%b exp=%b", i, {btn_level, btn_press}, {e.lvl, e.press});
      else n_pass++;
      n_checks++;
      if (rst_sys !== e.rsys) $display("FAIL press_rst cyc=%0d got=%b exp=%b", i, rst_sys, e.rsys);
      else n_pass++;
    end
    for (int i = 1; i <= 8; i++) begin
      btn_n[0] = 1'b1;
      sbq.push_back('{rsys: 1'b0, lvl: {1'b0, i < 6}, press: 2'b00, led: 2'b00});
      tick();
      e = sbq.pop_front();
      n_checks++;
      if ({btn_level, btn_press} !== {e.lvl, e.press})
        $display("FAIL release cyc=%0d got=%b exp=%b", i, {btn_level, btn_press}, {e.lvl, e.press});
      else n_pass++;
    end
  endtask

  // Level rises 6 cycles after the pad and falls 6 after release; the FSM follows
  // one cycle later, then holds rst_sys for 8 cycles from re-entering the hold state.
  task automatic test_rst_button();
    for (int i = 1; i <= 40; i++) begin
      btn_n[1] = (i <= 20) ? 1'b0 : 1'b1;
      sbq.push_back('{rsys: (i >= 7 && i <= 34), lvl: {(i >= 6 && i <= 25), 1'b0},
                      press: {i == 6, 1'b0}, led: 2'b00});
      tick();
      e = sbq.pop_front();
      n_checks++;
      if ({btn_level, btn_press} !== {e.lvl, e.press})
        $display("FAIL rstbtn_level cyc=%0d got=%b exp=%b", i, {btn_level, btn_press}, {e.lvl, e.press});
      else n_pass++;
      n_checks++;
      if (rst_sys !== e.rsys) $display("FAIL rstbtn_rst cyc=%0d got=%b exp=%b", i, rst_sys, e.rsys);
      else n_pass++;
    end
  endtask

  task automatic test_led_modes();
    int  scnt;
    logic [2:0] ph;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    led_mode = 4'b1110;
    led_invert = 2'b00;
    scnt = 0;
    for (int i = 1; i <= 24; i++) begin
      led_act[1] = (i == 3 || i == 5 || i == 14 || i == 18);
      if (led_act[1]) scnt = 5;
      else if (scnt > 0) scnt--;
      ph = 3'(i - 1);
      sbq.push_back('{rsys: 1'b1, lvl: 2'b00, press: 2'b00, led: {scnt != 0, ph[2]}});
      tick();
      e = sbq.pop_front();
      n_checks++;
      if (led_out[0] !== e.led[0]) $display("FAIL blink cyc=%0d got=%b exp=%b", i, led_out[0], e.led[0]);
      else n_pass++;
      n_checks++;
      if (led_out[1] !== e.led[1]) $display("FAIL stretch cyc=%0d got=%b exp=%b", i, led_out[1], e.led[1]);
      else n_pass++;
    end
    led_act = 2'b00;
  endtask

  task automatic test_invert_reset();
    logic [2:0] ph;
    led_mode = 4'b0101;
    led_invert = 2'b01;
    sbq.push_back('{rsys: 1'b0, lvl: 2'b00, press: 2'b00, led: 2'b10});
    tick();
    e = sbq.pop_front();
    n_checks++;
    if (led_out !== e.led) $display("FAIL invert got=%b exp=%b", led_out, e.led);
    else n_pass++;
    led_invert = 2'b00;
    led_mode = 4'b1110;
    led_act = 2'b10;
    tick();
    led_act = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    sbq.push_back('{rsys: 1'b1, lvl: 2'b00, press: 2'b00, led: 2'b00});
    tick();
    e = sbq.pop_front();
    n_checks++;
    if (led_out !== e.led) $display("FAIL led_rst got=%b exp=%b", led_out, e.led);
    else n_pass++;
    n_checks++;
    if (rst_sys !== e.rsys) $display("FAIL rst_sys_rst got=%b exp=%b", rst_sys, e.rsys);
    else n_pass++;
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      ph = 3'(i - 1);
      sbq.push_back('{rsys: 1'b1, lvl: 2'b00, press: 2'b00, led: {1'b0, ph[2]}});
      tick();
      e = sbq.pop_front();
      n_checks++;
      if (led_out !== e.led) $display("FAIL led_restart cyc=%0d got=%b exp=%b", i, led_out, e.led);
      else n_pass++;
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_debounce();
    test_rst_button();
    test_led_modes();
    test_invert_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
